// File: rtl/exec_step_controller.sv
// exec_step_controller
// Sequences the single-cycle RISC-V core: issues a one-cycle cpu_en pulse
// either on a manual single-step request or, in RUN mode, once every RUN_DIV
// clock cycles. Counts issued pulses (wrapping at 2^CNT_W).
//
// Optional feature, macro EXEC_BREAKPOINT_EN:
//   when defined, the PC reported by the core on the cycle after each RUN
//   pulse is compared with bp_addr; a match parks the controller in BREAK.
//   When undefined, BREAK is unreachable, bp_hit is tied low and pc_in /
//   bp_addr are ignored.
module exec_step_controller #(
    parameter int RUN_DIV = 25000000,
    parameter int CNT_W   = 16,
    parameter int PC_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_req,
    input  logic             run_toggle,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_en,
    output logic             running,
    output logic             bp_hit,
    output logic [CNT_W-1:0] step_count
);

    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_RUN,
        S_BREAK
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] next_div;
    logic             div_wrap;
    logic             run_pulse;
    logic             bp_match;

    // Outputs decode straight from the state register so an asynchronous
    // reset drops them in the same instant.
    assign running = (state == S_RUN);
    assign cpu_en  = (state == S_STEP) || run_pulse;
    assign div_wrap = (divider == DIV_LAST);

`ifdef EXEC_BREAKPOINT_EN
    logic run_pulse_q;   // a RUN pulse was issued last cycle: pc_in is fresh
    logic skip_q;        // first pulse after resuming from BREAK is not compared

    assign bp_hit   = (state == S_BREAK);
    assign bp_match = run_pulse_q && !skip_q && (pc_in == bp_addr);

    // Track the post-pulse compare slot and the resume-from-break exemption.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_pulse_q <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            run_pulse_q <= run_pulse;
            if (state == S_BREAK && run_toggle) begin
                skip_q <= 1'b1;
            end else if (state == S_IDLE && run_toggle) begin
                skip_q <= 1'b0;
            end else if (state == S_RUN && run_pulse_q) begin
                skip_q <= 1'b0;
            end
        end
    end
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign bp_match  = 1'b0;
    assign unused_bp = ^{pc_in, bp_addr};
`endif

    // Next-state, run pulse and divider update.
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        next_div   = '0;
        run_pulse  = 1'b0;
        case (state)
            S_IDLE: begin
                // run_toggle has priority: a coincident step_req is dropped.
                if (run_toggle) begin
                    next_state = S_RUN;
                end else if (step_req) begin
                    next_state = S_STEP;
                end
            end
            S_STEP: begin
                next_state = S_IDLE;
            end
            S_RUN: begin
                // Leaving RUN on the pulse cycle suppresses that pulse.
                run_pulse = div_wrap && !run_toggle;
                if (run_toggle) begin
                    next_state = S_IDLE;
                end else if (bp_match) begin
                    next_state = S_BREAK;
                end
            end
            S_BREAK: begin
                if (run_toggle) begin
                    next_state = S_RUN;
                end else if (step_req) begin
                    next_state = S_STEP;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Divider only runs while staying in RUN; any entry starts from zero.
        if (state == S_RUN && next_state == S_RUN) begin
            next_div = div_wrap ? '0 : divider + DIV_W'(1);
        end
    end

    // State, divider and retired-step counter registers.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            divider    <= '0;
            step_count <= '0;
        end else begin
            state   <= next_state;
            divider <= next_div;
            if (cpu_en) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

endmodule
